// File: rtl/lfsr_sym_src_if.sv
// Symbol stream from the LFSR source to its consumer.
// A symbol transfers on a clk edge where sym_valid=1 and sym_ready=1; while sym_valid=1 and
// sym_ready=0 the source holds sym_data stable, and sym_valid never drops without a transfer
// except on reseed or reset.
interface lfsr_sym_src_if #(
    parameter int SYM_BITS = 2
);
    logic                sym_valid;
    logic                sym_ready;
    logic [SYM_BITS-1:0] sym_data;

    modport master (output sym_valid, output sym_data, input sym_ready);
    modport slave  (input sym_valid, input sym_data, output sym_ready);
endinterface

// File: rtl/lfsr_sym_src.sv
// Galois LFSR symbol source with reseed, period counter and optional symbol-cycle flags.
// Define LFSR_CYCLE_FLAGS_EN to build the cycle index and the four cycle outputs.
module lfsr_sym_src #(
    parameter int          LFSR_LEN        = 22,
    parameter int          SYM_BITS        = 2,
    parameter logic [31:0] SEED            = 32'd1,
    parameter int          CYCLES_PER_FLAG = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                seed_load,
    input  logic [LFSR_LEN-1:0] seed_in,
    lfsr_sym_src_if.master      sym_if,
    output logic [LFSR_LEN-1:0] seq_out,
    output logic [LFSR_LEN-1:0] period_count,
    output logic                seed_err,
    output logic                cycle_pulse,
    output logic                cycle_pulse_ahead,
    output logic                cycle_pulse_behind,
    output logic                cycle_once
);

    // Primitive polynomial feedback masks (x^L term implied), indexed by register length.
    localparam logic [31:0] TAP_TABLE [5:32] = '{
        32'h0000_0005, 32'h0000_0021, 32'h0000_0041, 32'h0000_0071,
        32'h0000_0021, 32'h0000_0081, 32'h0000_0201, 32'h0000_0053,
        32'h0000_001B, 32'h0000_002B, 32'h0000_4001, 32'h0000_A011,
        32'h0000_4001, 32'h0000_0801, 32'h0000_0047, 32'h0002_0001,
        32'h0008_0001, 32'h0020_0001, 32'h0004_0001, 32'h00C2_0001,
        32'h0040_0001, 32'h0000_0047, 32'h0000_0027, 32'h0200_0001,
        32'h0800_0001, 32'h0000_0053, 32'h1000_0001, 32'h0040_0007
    };
    localparam logic [LFSR_LEN-1:0] TAPMASK = LFSR_LEN'(TAP_TABLE[LFSR_LEN]);
    localparam logic [LFSR_LEN-1:0] SEED_V  = LFSR_LEN'(SEED);

    logic [LFSR_LEN-1:0] state;
    logic [LFSR_LEN-1:0] active_seed;
    logic [LFSR_LEN-1:0] next_state;
    logic [LFSR_LEN-1:0] load_val;
    logic [LFSR_LEN-1:0] pc_next;
    logic                advance;
    logic                wrap;

    assign next_state = {state[LFSR_LEN-2:0], 1'b0} ^ (state[LFSR_LEN-1] ? TAPMASK : '0);
    assign advance    = enable && !seed_load && (!sym_if.sym_valid || sym_if.sym_ready);
    assign wrap       = (next_state == active_seed);
    assign load_val   = (seed_in == '0) ? SEED_V : seed_in;
    assign pc_next    = wrap ? LFSR_LEN'(1) : period_count + 1'b1;
    assign seq_out    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= SEED_V;
            active_seed      <= SEED_V;
            period_count     <= LFSR_LEN'(1);
            sym_if.sym_valid <= 1'b0;
            sym_if.sym_data  <= '0;
            seed_err         <= 1'b0;
        end else begin
            seed_err <= 1'b0;
            // Reseed wins over an advance; a symbol accepted on this edge was the last of the old run.
            if (seed_load) begin
                state            <= load_val;
                active_seed      <= load_val;
                period_count     <= LFSR_LEN'(1);
                sym_if.sym_valid <= 1'b0;
                seed_err         <= (seed_in == '0);
            end else if (advance) begin
                state            <= next_state;
                sym_if.sym_data  <= next_state[SYM_BITS-1:0];
                period_count     <= pc_next;
                sym_if.sym_valid <= 1'b1;
            end
        end
    end

`ifdef LFSR_CYCLE_FLAGS_EN
    localparam int IDX_W = (CYCLES_PER_FLAG > 1) ? $clog2(CYCLES_PER_FLAG) : 1;

    logic [IDX_W-1:0] cyc_idx;
    logic             behind_pend;
    logic             last_idx;

    assign last_idx = (cyc_idx == IDX_W'(CYCLES_PER_FLAG - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_idx            <= '0;
            behind_pend        <= 1'b0;
            cycle_pulse        <= 1'b0;
            cycle_pulse_ahead  <= 1'b0;
            cycle_pulse_behind <= 1'b0;
            cycle_once         <= 1'b0;
        end else begin
            cycle_pulse        <= 1'b0;
            cycle_pulse_ahead  <= 1'b0;
            cycle_pulse_behind <= 1'b0;
            if (seed_load) begin
                cyc_idx     <= '0;
                behind_pend <= 1'b0;
            end else if (advance) begin
                if (behind_pend) begin
                    cycle_pulse_behind <= 1'b1;
                    behind_pend        <= 1'b0;
                end
                if (wrap) begin
                    if (last_idx) begin
                        cyc_idx     <= '0;
                        cycle_pulse <= 1'b1;
                        cycle_once  <= 1'b1;
                        behind_pend <= 1'b1;
                    end else begin
                        cyc_idx <= cyc_idx + 1'b1;
                    end
                end
                if ((pc_next == '1) && last_idx) begin
                    cycle_pulse_ahead <= 1'b1;
                end
            end
        end
    end
`else
    assign cycle_pulse        = 1'b0;
    assign cycle_pulse_ahead  = 1'b0;
    assign cycle_pulse_behind = 1'b0;
    assign cycle_once         = 1'b0;
`endif

endmodule

// File: doc/lfsr_sym_src.md
LFSR_SYM_SRC -- requirements
Module: lfsr_sym_src

Interface
REQ-001 The block SHALL have these parameters:
- LFSR_LEN, default 22: register length; legal range 5..32.
- SYM_BITS, default 2: symbol width; legal range 1..8, and SHALL NOT exceed LFSR_LEN.
- SEED, default 1: reset and fallback seed; SHALL be nonzero.
- CYCLES_PER_FLAG, default 4: number of LFSR periods per symbol-cycle flag; legal range 1..16.
REQ-002 The block SHALL have these ports:
- clk, in, 1: clock.
- reset, in, 1: reset, asynchronous, active-high.
- enable, in, 1: run gate.
- seed_load, in, 1: synchronous reseed strobe.
- seed_in, in, LFSR_LEN: new seed value.
- sym_ready, in, 1: consumer accepts sym_data.
- sym_valid, out, 1: sym_data holds a valid symbol.
- sym_data, out, SYM_BITS: current symbol.
- seq_out, out, LFSR_LEN: full LFSR state.
- period_count, out, LFSR_LEN: advance index within the current period.
- seed_err, out, 1: zero-seed substitution occurred.
- cycle_pulse, out, 1: symbol-cycle completion pulse.
- cycle_pulse_ahead, out, 1: pulse one advance before cycle_pulse.
- cycle_pulse_behind, out, 1: pulse one advance after cycle_pulse.
- cycle_once, out, 1: sticky flag, first symbol-cycle completed.

Function
REQ-003 The LFSR SHALL be Galois-form: next = {state[L-2:0],1'b0} XOR (state[L-1] ? TAPMASK : 0), where L = LFSR_LEN.
REQ-004 TAPMASK SHALL come from a localparam table of primitive polynomials covering L = 5..32; required entries are L=5 mask 0x05, L=8 mask 0x71, and L=22 mask 0x200001.
REQ-005 An advance SHALL occur on a clk edge when enable=1, seed_load=0, and (sym_valid=0 or sym_ready=1).
REQ-006 On each advance, sym_data SHALL take next[SYM_BITS-1:0], seq_out SHALL take next, and sym_valid SHALL be 1.
REQ-007 Latency SHALL be one clk from the advance edge to updated outputs.
REQ-008 When sym_valid=1 and sym_ready=0, sym_data, seq_out and all counters SHALL hold unchanged (backpressure).
REQ-009 When enable=0, no advance SHALL occur; sym_valid SHALL hold its value, and any pending symbol SHALL remain until accepted.
REQ-010 The block SHALL keep an internal active-seed register.
REQ-011 On an advance whose next state equals the active seed, period_count SHALL become 1; otherwise period_count SHALL increment by 1.
REQ-012 period_count SHALL never exceed 2^L-1.
REQ-013 seed_load=1 SHALL take priority over an advance. On that edge:
- state and active seed SHALL load seed_in;
- period_count SHALL become 1;
- the cycle index SHALL become 0;
- sym_valid SHALL become 0.
REQ-014 If seed_in is all-zero at seed_load, SEED SHALL be loaded instead, and seed_err SHALL be 1 for exactly one clk.
REQ-015 A seed_load coincident with a valid-ready transfer SHALL discard the next symbol; the accepted symbol is the last one of the old sequence.

Reset
REQ-016 While reset=1, the block SHALL hold:
- state, active seed and seq_out = SEED;
- period_count = 1;
- sym_valid = 0;
- sym_data = 0;
- seed_err = 0;
- all cycle outputs = 0;
- cycle index = 0.
REQ-017 After reset deasserts, the first advance SHALL present the state following SEED.
REQ-018 Reset asserted mid-backpressure SHALL drop the pending symbol.

Configuration
REQ-019 The macro LFSR_CYCLE_FLAGS_EN SHALL control the symbol-cycle flag logic.
REQ-020 With LFSR_CYCLE_FLAGS_EN defined, the block SHALL keep a cycle index counting completed periods modulo CYCLES_PER_FLAG.
REQ-021 With the macro defined, cycle_pulse SHALL be 1 for one clk after the advance that wraps period_count to 1 while the cycle index is CYCLES_PER_FLAG-1; that same advance SHALL set the index to 0.
REQ-022 With the macro defined, cycle_pulse_ahead SHALL be 1 for one clk after the advance giving period_count = 2^L-1 while the index is CYCLES_PER_FLAG-1.
REQ-023 With the macro defined, cycle_pulse_behind SHALL be 1 for one clk after the first advance following a cycle_pulse.
REQ-024 With the macro defined, cycle_once SHALL set together with the first cycle_pulse and SHALL stay set until reset.
REQ-025 Without LFSR_CYCLE_FLAGS_EN, the cycle index SHALL be absent and all four cycle outputs SHALL be tied to 0.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- L=5, SEED=1, sym_ready=1, enable=1 -> seq_out 0x02, 0x04, 0x08, 0x10, 0x05 on successive clks; state returns to 0x01 after 31 advances with period_count=1.
- L=8, L=22 free-run -> no state repeats before 2^L-1 advances, and the state equals the seed at advance 2^L-1.
- sym_ready=0 for 5 clks after sym_valid=1 -> sym_data, seq_out and period_count frozen; advance resumes on the first clk with sym_ready=1.
- seed_load with seed_in=0 -> state=SEED, seed_err pulses one clk, sym_valid=0, period_count=1.
- flags enabled, L=5, CYCLES_PER_FLAG=4, continuous ready -> cycle_pulse_ahead after advance 123, cycle_pulse after advance 124, cycle_pulse_behind after advance 125, cycle_once set with the first cycle_pulse; flags disabled -> all four outputs 0.
- reset asserted during backpressure -> all outputs at reset values within the same clk; sequence restarts from SEED.
